ena_qual_trigger: RTL
=====================

ENA_QUAL_TRIGGER -- requirements
Module: ena_qual_trigger

Interface
REQ-001 Parameter CH, default 4, number of independent enable/trigger channels (1..32).
REQ-002 Parameter LEN_W, default 4, width of the qualification-length field and per-channel run counter (2..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  CH  per-channel enable, sampled each rising edge of clk.
REQ-006 cfg_len  input  LEN_W  required number of consecutive high ena samples; shared by all channels; 0 = channels disabled.
REQ-007 cfg_pulse  input  1  output mode: 0 = level, 1 = single-cycle pulse.
REQ-008 sts_clr  input  CH  per-channel write-1 clear of the sticky fired flag.
REQ-009 trigger  output  CH  registered per-channel trigger.
REQ-010 sts_fired  output  CH  registered sticky flag: channel has qualified since last clear.

Function
REQ-011 Each channel SHALL keep a run counter cnt[LEN_W-1:0] counting consecutive edges with ena high.
REQ-012 At an edge with ena[i]=0, cnt[i] SHALL load 0; with ena[i]=1, cnt[i] SHALL increment, saturating at 2^LEN_W-1 (no wrap).
REQ-013 Qualify event q[i] SHALL be true at an edge when ena[i]=1, cfg_len!=0 and cnt[i] >= cfg_len-1 (pre-increment value).
REQ-014 Latency: with ena[i] high from edge 1 onward, trigger[i] SHALL first be high after edge cfg_len (cfg_len=4 -> after edge 4).
REQ-015 Level mode: trigger[i] SHALL load q[i] each edge; it SHALL stay high while ena[i] stays high and drop after the first edge sampling ena[i]=0.
REQ-016 Pulse mode: each channel SHALL have an armed bit, set at reset; at an edge with q[i]=1 and armed, trigger[i] SHALL be high for exactly one cycle and armed SHALL clear.
REQ-017 Pulse mode: armed[i] SHALL set again only at an edge sampling ena[i]=0; ena held high indefinitely SHALL produce only one pulse.
REQ-018 Level mode: armed[i] SHALL track the same rules as in pulse mode so that a mode switch never produces a spurious pulse.
REQ-019 cfg_len=0: q SHALL be false for all channels and trigger SHALL be 0 after the next edge; counters keep running.
REQ-020 cfg_len=1: trigger SHALL assert after the first edge sampling ena high.
REQ-021 cfg_len changes SHALL take effect at the next edge against the current cnt; lowering cfg_len below a running cnt SHALL qualify immediately.
REQ-022 Saturated cnt with cfg_len = 2^LEN_W-1 SHALL still qualify (saturation value >= cfg_len-1).
REQ-023 sts_fired[i] SHALL set at any edge where trigger[i] loads 1; sts_clr[i] SHALL clear it; set SHALL win over simultaneous clear.
REQ-024 Channels SHALL be fully independent; no cross-channel interaction except shared cfg_len/cfg_pulse.
REQ-025 cfg_pulse change SHALL take effect at the next edge; a level-high trigger switched to pulse mode SHALL drop unless armed and qualifying.

Reset
REQ-026 On rst_n low, asynchronously: cnt=0, trigger=0, sts_fired=0, armed=1 for all channels.
REQ-027 Reset mid-run SHALL discard progress; after release, qualification SHALL require a fresh cfg_len consecutive high samples.
REQ-028 Outputs SHALL hold reset values until the first rising clk edge after rst_n deasserts.

Verification
REQ-029 Level, cfg_len=4, ena[0] high 10 edges then low -> trigger[0] high after edges 4..10, low after edge 11; sts_fired[0]=1.
REQ-030 Pulse, cfg_len=3, ena[1] high 8 edges, low 1, high 3 -> trigger[1] high only after edge 3 and after edge 12, one cycle each.
REQ-031 cfg_len=4, ena[2] pattern 1,1,1,0,1,1,1,1 -> trigger[2] first high after edge 8 only.
REQ-032 cfg_len=0, all ena high 20 edges -> trigger=0 throughout; then cfg_len=2 -> all triggers high after next edge.
REQ-033 LEN_W=4, cfg_len=15, ena[3] high 30 edges -> cnt saturates at 15, trigger[3] high from edge 15 to 30 without drop.
REQ-034 rst_n pulsed low after edge 3 of a cfg_len=4 run, ena held high -> trigger stays 0 until 4th edge after release; sts_clr with simultaneous fire -> sts_fired stays 1.

Source files
------------

// File: rtl/ena_qual_trigger.sv
// rtl/ena_qual_trigger.sv - per-channel enable qualifier with level/pulse trigger and sticky status
//
// Each channel counts consecutive rising edges that sample its enable high.
// Once the run reaches the shared qualification length, the channel triggers:
// either as a level that follows qualification, or as a single-cycle pulse
// that re-arms only after the enable is seen low.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   ena        [CH]    per-channel enable, sampled every edge
//   cfg_len    [LEN_W] required consecutive high samples (0 disables all channels)
//   cfg_pulse  output mode: 0 = level, 1 = single-cycle pulse
//   sts_clr    [CH]    write-1 clear of the sticky fired flags
//   trigger    [CH]    registered per-channel trigger
//   sts_fired  [CH]    registered sticky "has qualified since last clear" flags

module ena_qual_trigger #(
    parameter int CH    = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    ena,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_pulse,
    input  logic [CH-1:0]    sts_clr,
    output logic [CH-1:0]    trigger,
    output logic [CH-1:0]    sts_fired
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    logic [LEN_W-1:0] cnt [CH];
    logic [CH-1:0]    armed;
    logic [CH-1:0]    qual;
    logic [CH-1:0]    trig_nxt;
    logic             len_nz;
    logic [LEN_W-1:0] len_m1;

    assign len_nz = (cfg_len != '0);
    // Only consulted when cfg_len is non-zero, so the subtraction never wraps
    // in a way that matters.
    assign len_m1 = cfg_len - LEN_W'(1);

    // Qualification compares the pre-increment count against cfg_len-1, so
    // a channel fires on the cfg_len-th consecutive high sample. The armed
    // bit is honoured only in pulse mode, but it is maintained in both modes
    // so switching to pulse mode cannot produce a stale pulse.
    always_comb begin
        qual     = '0;
        trig_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            qual[i]     = ena[i] && len_nz && (cnt[i] >= len_m1);
            trig_nxt[i] = cfg_pulse ? (qual[i] && armed[i]) : qual[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
            armed     <= '1;
            trigger   <= '0;
            sts_fired <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!ena[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + LEN_W'(1);
                end
            end
            // Re-arm on any low sample; disarm on the first qualifying edge.
            armed     <= ~ena | (armed & ~qual);
            trigger   <= trig_nxt;
            // A new fire takes priority over a simultaneous clear.
            sts_fired <= trig_nxt | (sts_fired & ~sts_clr);
        end
    end

endmodule
